universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/usr_pkg.sv | 15 +
 rtl/shift_counter.sv | 36 +++
 rtl/universal_shift_register.sv | 67 ++++++
 tb/tb_universal_shift_register.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_SET   = 3'b111
  } mode_t;

endpackage

// File: rtl/shift_counter.sv
// Counts shift/rotate edges and pulses done for one cycle every WIDTH shifts.
module shift_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        // Reaching WIDTH wraps straight to zero; the wrap itself raises done.
        if (cnt == CW'(WIDTH - 1)) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold/load/shift/rotate/clear/set with shift-complete pulse.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int             WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             sout,
  output logic             done
);

  mode_t op;
  logic  inc;
  logic  clr;

  assign op = mode_t'(mode);
  assign nQ = ~Q;

  always_comb begin
    sout = Q[0];
    inc  = 1'b0;
    clr  = 1'b0;
    case (op)
      MODE_SHL, MODE_ROL: begin
        sout = Q[WIDTH-1];
        inc  = 1'b1;
      end
      MODE_SHR, MODE_ROR:               inc = 1'b1;
      MODE_LOAD, MODE_CLEAR, MODE_SET:  clr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= RESET_VALUE;
    end else begin
      case (op)
        MODE_HOLD:  Q <= Q;
        MODE_LOAD:  Q <= D;
        MODE_SHL:   Q <= {Q[WIDTH-2:0], sin};
        MODE_SHR:   Q <= {sin, Q[WIDTH-1:1]};
        MODE_ROL:   Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
        MODE_ROR:   Q <= {Q[0], Q[WIDTH-1:1]};
        MODE_CLEAR: Q <= '0;
        MODE_SET:   Q <= '1;
        default:    Q <= Q;
      endcase
    end
  end

  shift_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .clr  (clr),
    .done (done)
  );

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: driver predicts each edge from an arithmetic model, monitor compares.
`timescale 1ns/1ps
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   mode;
  logic [W-1:0] D;
  logic         sin;
  logic [W-1:0] Q, nQ;
  logic         sout, done;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst(rst), .mode(mode), .D(D), .sin(sin),
    .Q(Q), .nQ(nQ), .sout(sout), .done(done)
  );

  always #41.667 clk = ~clk;  // ~12 MHz

  typedef struct {
    bit         chk_sout;
    logic       sout;
    logic [7:0] q;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: value as plain arithmetic, shifts counted since last clear.
  logic [7:0] mq;
  int         shifts;
  bit         mvalid = 0;

  task automatic cyc(input bit r, input mode_t m, input logic [7:0] d, input logic s);
    exp_t e;
    bit   pulse;
    @(negedge clk);
    rst = r; mode = m; D = d; sin = s;
    e.chk_sout = mvalid;
    e.sout     = (m == MODE_SHL || m == MODE_ROL) ? mq[7] : mq[0];
    pulse = 0;
    if (r) begin
      mq = RV; shifts = 0; mvalid = 1;
    end else begin
      case (m)
        MODE_HOLD:  ;
        MODE_LOAD:  begin mq = d;     shifts = 0; end
        MODE_CLEAR: begin mq = 8'h00; shifts = 0; end
        MODE_SET:   begin mq = 8'hFF; shifts = 0; end
        default: begin
          case (m)
            MODE_SHL: mq = 8'((mq * 2) + s);
            MODE_SHR: mq = 8'((mq / 2) + (s * 128));
            MODE_ROL: mq = 8'((mq * 2) + (mq / 128));
            default:  mq = 8'((mq / 2) + ((mq % 2) * 128));
          endcase
          shifts++;
          pulse = (shifts % W == 0);
        end
      endcase
    end
    e.q    = mq;
    e.done = pulse;
    sb.push_back(e);
  endtask

  // Monitor: sout sampled mid-low-phase (pre-edge), Q/nQ/done just after the edge.
  initial begin
    logic s_sout;
    exp_t e;
    forever begin
      @(negedge clk);
      #5 s_sout = sout;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_sout) begin
          checks++;
          if (s_sout !== e.sout) begin
            errors++;
            $display("FAIL sout actual=%b expected=%b t=%0t", s_sout, e.sout, $time);
          end
        end
        checks++;
        if (Q !== e.q) begin
          errors++;
          $display("FAIL Q actual=%h expected=%h t=%0t", Q, e.q, $time);
        end
        checks++;
        if (nQ !== ~e.q) begin
          errors++;
          $display("FAIL nQ actual=%h expected=%h t=%0t", nQ, ~e.q, $time);
        end
        checks++;
        if (done !== e.done) begin
          errors++;
          $display("FAIL done actual=%b expected=%b t=%0t", done, e.done, $time);
        end
      end
    end
  end

  initial begin
    mode_t rm;
    int    waitc;
    rst = 0; mode = MODE_HOLD; D = '0; sin = 0;
    // Reset with load requested, then load/hold
    cyc(1, MODE_LOAD, 8'hFF, 0);
    cyc(0, MODE_LOAD, 8'h3C, 0);
    repeat (3) cyc(0, MODE_HOLD, 8'h00, 0);
    // Shift in ones; done after the 8th edge
    cyc(0, MODE_LOAD, 8'h00, 0);
    repeat (8) cyc(0, MODE_SHL, 8'h00, 1);
    cyc(0, MODE_HOLD, 8'h00, 0);
    // Rotate right full circle
    cyc(0, MODE_LOAD, 8'h81, 0);
    repeat (8) cyc(0, MODE_ROR, 8'h00, 0);
    cyc(0, MODE_HOLD, 8'h00, 0);
    // Hold keeps count; direction changes keep count
    cyc(0, MODE_LOAD, 8'h5A, 0);
    repeat (4) cyc(0, MODE_SHL, 8'h00, 1);
    repeat (2) cyc(0, MODE_HOLD, 8'h00, 0);
    repeat (2) cyc(0, MODE_SHR, 8'h00, 0);
    repeat (2) cyc(0, MODE_ROL, 8'h00, 0);
    // Clear in the middle suppresses done
    repeat (4) cyc(0, MODE_SHR, 8'h00, 1);
    cyc(0, MODE_CLEAR, 8'h00, 0);
    repeat (4) cyc(0, MODE_SHR, 8'h00, 1);
    cyc(0, MODE_SET, 8'h00, 0);
    repeat (4) cyc(0, MODE_ROR, 8'h00, 0);
    // Reset mid-sequence
    cyc(0, MODE_LOAD, 8'h00, 0);
    repeat (5) cyc(0, MODE_SHL, 8'h00, 1);
    cyc(1, MODE_SHL, 8'h00, 1);
    repeat (3) cyc(0, MODE_SHL, 8'h00, 0);
    repeat (5) cyc(0, MODE_SHL, 8'h00, 1);
    cyc(0, MODE_HOLD, 8'h00, 0);
    // Randomized traffic, biased toward shift/rotate
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) rm = mode_t'(3'($urandom_range(2, 5)));
      else                           rm = mode_t'(3'($urandom_range(0, 7)));
      cyc(($urandom_range(0, 49) == 0), rm, 8'($urandom), 1'($urandom));
    end
    cyc(0, MODE_HOLD, 8'h00, 0);
    waitc = 0;
    while (sb.size() > 0 && waitc < 20) begin
      @(posedge clk);
      waitc++;
    end
    #10;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
